// File: rtl/t_to_s_stream_if.sv
// Stream interface for the two's-complement to sign-magnitude converter.
// Carries both the input and the output handshake; the converter takes the
// slave view and the producer/consumer pair takes the master view.
interface t_to_s_stream_if #(
  parameter int DATA_WIDTH = 6,
  parameter int LANES      = 2
);

  // Input side: two's-complement beats from the arithmetic units.
  logic                          in_valid;
  logic                          in_ready;
  logic [LANES*DATA_WIDTH-1:0]   in_data;

  // Output side: sign-magnitude beats toward message storage.
  logic                          out_valid;
  logic                          out_ready;
  logic [LANES*DATA_WIDTH-1:0]   out_data;
  logic [LANES-1:0]              out_sat;

  // Producer/consumer view.
  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat,
    output out_ready
  );

  // Converter view.
  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat,
    input  out_ready
  );

endinterface

// File: rtl/t_to_s_stream.sv
// Two's-complement to sign-magnitude stream converter for LLR/message words.
// Each lane is converted as the beat enters a 2-entry FIFO, so stored entries
// already hold sign-magnitude data plus a per-lane saturation flag. The
// most-negative code has no sign-magnitude equivalent; it is clamped to the
// largest negative magnitude and counted in sat_count.
module t_to_s_stream #(
  parameter int DATA_WIDTH = 6,
  parameter int LANES      = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  t_to_s_stream_if.slave       bus,
  input  logic                 sat_clear,
  output logic [CNT_WIDTH-1:0] sat_count
);

  localparam int BEAT_WIDTH = LANES * DATA_WIDTH;
  localparam int INC_WIDTH  = $clog2(LANES + 1);
  localparam int SUM_WIDTH  = CNT_WIDTH + 1;

  typedef struct packed {
    logic [BEAT_WIDTH-1:0] data;
    logic [LANES-1:0]      sat;
  } entry_t;

  // FIFO storage and bookkeeping. The head entry register drives the outputs
  // directly, so nothing on the output side depends on the inputs.
  entry_t         mem [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     count;

  entry_t                 conv;
  logic [DATA_WIDTH-1:0]  word;
  logic [DATA_WIDTH-1:0]  neg;
  logic [INC_WIDTH-1:0]   sat_inc;
  logic [SUM_WIDTH-1:0]   sat_sum;

  logic accept;
  logic pop;

  // Handshake: in_ready comes from registered occupancy and reset only, so
  // there is no combinational path from out_ready or in_valid.
  assign bus.in_ready  = !rst && (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[rd_ptr].data;
  assign bus.out_sat   = mem[rd_ptr].sat;

  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;

  // Per-lane conversion of the incoming beat and count of saturated lanes.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    conv    = '0;
    word    = '0;
    neg     = '0;
    sat_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      word = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
      neg  = -word;
      if (!word[DATA_WIDTH-1]) begin
        // Non-negative: the word is already valid sign-magnitude.
        conv.data[i*DATA_WIDTH +: DATA_WIDTH] = word;
      end else if (word[DATA_WIDTH-2:0] == '0) begin
        // Most-negative code: clamp to the largest negative magnitude.
        conv.data[i*DATA_WIDTH +: DATA_WIDTH] = '1;
        conv.sat[i] = 1'b1;
        sat_inc     = sat_inc + INC_WIDTH'(1);
      end else begin
        // Ordinary negative: sign bit plus the magnitude of -x. Since the
        // magnitude is never zero here, negative zero cannot appear.
        conv.data[i*DATA_WIDTH +: DATA_WIDTH] = {1'b1, neg[DATA_WIDTH-2:0]};
      end
    end
  end

  // Counter sum one bit wider than the counter so overflow is visible.
  always_comb begin
    sat_sum = {1'b0, sat_count} + SUM_WIDTH'(sat_inc);
  end

  // FIFO state: write on accept, advance the head on pop, track occupancy.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, regardless of statement order.
    if (rst) begin
      // NOTE: the two storage entries are reset because out_data/out_sat
      // must read zero after reset and are driven straight from the head.
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= conv;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Saturation event counter: clear wins over increment, and it sticks at
  // all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst || sat_clear) begin
      sat_count <= '0;
    end else if (accept) begin
      if (sat_sum[CNT_WIDTH]) begin
        sat_count <= '1;
      end else begin
        sat_count <= sat_sum[CNT_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_t_to_s_stream.sv
// Self-checking bench for t_to_s_stream. A monitor on the falling edge
// mirrors the buffer with a scoreboard queue: every accepted beat pushes its
// reference sign-magnitude result, every pop compares the head.
module tb_t_to_s_stream;

  localparam int DW = 6;
  localparam int L  = 2;
  localparam int CW = 16;
  localparam int BW = DW * L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sat_clear = 1'b0;
  logic [CW-1:0] sat_count;

  t_to_s_stream_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();

  t_to_s_stream #(
    .DATA_WIDTH(DW),
    .LANES     (L),
    .CNT_WIDTH (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .sat_clear(sat_clear),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    logic [L-1:0]  sat;
  } exp_t;

  exp_t sb[$];
  int   model_cnt = 0;
  bit   mon_en    = 1'b0;
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   n_out     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
  endtask

  // Reference conversion using signed integer arithmetic.
  function automatic exp_t model(input logic [BW-1:0] beat, output int nsat);
    exp_t          e;
    logic [DW-1:0] w;
    int            v;
    int            m;
    logic          sg;
    e.data = '0;
    e.sat  = '0;
    nsat   = 0;
    for (int i = 0; i < L; i++) begin
      w = beat[i*DW +: DW];
      v = int'($signed(w));
      if (v >= 0) begin
        sg = 1'b0; m = v;
      end else if (v == -(1 << (DW - 1))) begin
        sg = 1'b1; m = (1 << (DW - 1)) - 1; e.sat[i] = 1'b1; nsat++;
      end else begin
        sg = 1'b1; m = -v;
      end
      e.data[i*DW +: DW] = {sg, m[DW-2:0]};
    end
    return e;
  endfunction

  // Monitor: compare registered outputs, then advance the model for the
  // upcoming rising edge using the inputs that edge will see.
  always @(negedge clk) begin
    bit   exp_ir;
    bit   exp_ov;
    bit   acc;
    bit   pp;
    int   ns;
    exp_t e;
    if (mon_en) begin
      exp_ir = !rst && (sb.size() != 2);
      exp_ov = (sb.size() != 0);
      check("in_ready", 32'(bus.in_ready), 32'(exp_ir));
      check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      check("sat_count", 32'(sat_count), 32'(model_cnt));
      if (rst) begin
        sb.delete();
        model_cnt = 0;
      end else begin
        pp  = exp_ov && bus.out_ready;
        acc = bus.in_valid && exp_ir;
        if (pp) begin
          e = sb.pop_front();
          check("out_data", 32'(bus.out_data), 32'(e.data));
          check("out_sat", 32'(bus.out_sat), 32'(e.sat));
          n_out++;
        end
        e = model(bus.in_data, ns);
        if (sat_clear) model_cnt = 0;
        else if (acc) model_cnt = (model_cnt + ns > 65535) ? 65535 : model_cnt + ns;
        if (acc) sb.push_back(e);
      end
    end
  end

  // Present one beat and hold it until accepted, with a cycle budget.
  task automatic send(input logic [BW-1:0] d);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    if (!acc) check("send_timeout", 32'(0), 32'(1));
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    time t0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_in_ready", 32'(bus.in_ready), 32'(0));
    check("rst_out_data", 32'(bus.out_data), 32'(0));
    check("rst_out_sat", 32'(bus.out_sat), 32'(0));
    check("rst_sat_count", 32'(sat_count), 32'(0));
    mon_en = 1'b1;
    rst    = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus.in_ready), 32'(1));

    // Basic +5 / -5.
    send({6'b111011, 6'b000101});
    wait_empty();

    // Boundary words, including the most-negative code in lane 0.
    send({6'b011111, 6'b111111});
    send({6'b000000, 6'b100000});
    wait_empty();
    check("t2_sat_count", 32'(sat_count), 32'(1));

    // Backpressure: two beats fill the buffer, the third stalls.
    base = n_out;
    bus.out_ready = 1'b0;
    send({6'b000001, 6'b000010});
    send({6'b110000, 6'b001111});
    bus.in_valid = 1'b1;
    bus.in_data  = {6'b101010, 6'b010101};
    repeat (3) begin
      @(negedge clk);
      check("t3_blocked", 32'(bus.in_ready), 32'(0));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send({6'b101010, 6'b010101});
    send({6'b100001, 6'b011110});
    wait_empty();
    check("t3_beats_out", 32'(n_out - base), 32'(4));

    // Full-rate sweep of every 6-bit code in lane 0.
    base = n_out;
    t0   = $time;
    for (int i = 0; i < 64; i++) send({6'b000000, 6'(i)});
    check("t4_cycles", 32'(($time - t0) / 10), 32'(64));
    wait_empty();
    check("t4_beats_out", 32'(n_out - base), 32'(64));
    check("t4_sat_count", 32'(sat_count), 32'(2));

    // Clear priority over a same-cycle increment.
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
    send({6'b100000, 6'b100000});
    send({6'b100000, 6'b000000});
    wait_empty();
    check("t5_sat_count_pre", 32'(sat_count), 32'(3));
    sat_clear = 1'b1;
    send({6'b100000, 6'b100000});
    sat_clear = 1'b0;
    check("t5_sat_count_clr", 32'(sat_count), 32'(0));
    wait_empty();

    // Reset with a full buffer discards both beats.
    bus.out_ready = 1'b0;
    send({6'b111110, 6'b000011});
    send({6'b000111, 6'b111000});
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_out_valid", 32'(bus.out_valid), 32'(0));
    check("t6_in_ready", 32'(bus.in_ready), 32'(0));
    check("t6_out_data", 32'(bus.out_data), 32'(0));
    check("t6_out_sat", 32'(bus.out_sat), 32'(0));
    rst = 1'b0;
    #1;
    check("t6_ready_after", 32'(bus.in_ready), 32'(1));
    base = n_out;
    bus.out_ready = 1'b1;
    send({6'b110011, 6'b001100});
    wait_empty();
    check("t6_beats_out", 32'(n_out - base), 32'(1));

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/t_to_s_stream.md
Name: t_to_s_stream

Overview:
- Streaming converter from two's-complement to sign-magnitude for LLR/message words: the inverse of the sign-magnitude-to-two's-complement utility.
- Sits at the output of check-node and variable-node arithmetic, ahead of sign-magnitude message storage.
- Each beat carries LANES words. A valid/ready handshake in each direction is decoupled by a 2-entry buffer.
- The unrepresentable most-negative input is saturated and counted.

Parameters:
DATA_WIDTH, 6, bits per word (sign + DATA_WIDTH-1 magnitude bits)
LANES, 2, words per beat
CNT_WIDTH, 16, width of saturation event counter

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data holds a beat
in_ready  output  1  block can accept a beat this cycle
in_data  input  LANES*DATA_WIDTH  two's-complement words, lane 0 in LSBs
out_valid  output  1  out_data/out_sat hold a beat
out_ready  input  1  consumer accepts the beat this cycle
out_data  output  LANES*DATA_WIDTH  sign-magnitude words, lane 0 in LSBs
out_sat  output  LANES  per-lane flag: the word was saturated
sat_count  output  CNT_WIDTH  total saturated words since reset/clear
sat_clear  input  1  synchronous clear of sat_count

Behaviour:
- Per-lane conversion for input x with N = DATA_WIDTH:
  - x >= 0: out = {0, x[N-2:0]}, sat = 0.
  - x < 0 and x != -2^(N-1): out = {1, magnitude of -x in N-1 bits}, sat = 0.
  - x = -2^(N-1): out = {1, all ones}, i.e. magnitude 2^(N-1)-1, sat = 1.
  - Negative zero is never produced.
- Conversion is applied when a beat enters the buffer. Stored entries already hold converted data and sat flags.
- Handshake:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Pop occurs when out_valid && out_ready at a rising edge.
  - A transfer happens only on such an edge. Data must be held stable while valid is high and ready is low; the block does not check this on its inputs but guarantees it on its outputs.
- Buffer:
  - 2-entry FIFO with registered occupancy count 0..2.
  - out_valid = (count != 0).
  - out_data/out_sat are driven from the head entry register.
  - in_ready = !rst && (count != 2). It depends only on registered state; there is no combinational path from out_ready to in_ready or from in_valid to out_valid.
- Latency: a beat accepted at edge k appears with out_valid high in the cycle after edge k, provided the buffer was empty. Sustained throughput is 1 beat/cycle when out_ready is held high.
- Simultaneous accept and pop:
  - count=1: count stays 1; the head advances to the new beat in the same edge.
  - count=2: accept is impossible because in_ready=0.
  - count=0: no pop occurs; the beat is stored and count becomes 1.
- Ordering: strict FIFO with no drops or duplicates. out_ready low with count=2 holds in_ready low indefinitely.
- sat_count:
  - On each accept, add the number of lanes with sat=1.
  - Saturate at 2^CNT_WIDTH-1 with no wrap.
  - sat_clear has priority over increment in the same cycle: the counter becomes 0 and events from that cycle are discarded.
- Reset (rst high at an edge):
  - count=0, out_valid=0, out_data=0, out_sat=0, sat_count=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after rst deasserts.
  - Reset mid-transfer discards all buffered beats; no output beat emerges after reset for a beat accepted before it.

Test Plan:
1. DATA_WIDTH=6, LANES=2, out_ready=1: beat lanes {+5=000101, -5=111011} -> one cycle later out_data lanes {000101, 100101}, out_sat=00, sat_count=0.
2. Boundary words, beats {-1=111111, +31=011111} then {-32=100000, 0=000000} -> {100001, 011111} sat=00, then {111111, 000000} sat=01 (lane 0 flagged), sat_count=1.
3. Backpressure: out_ready=0, in_valid=1 for 4 cycles with beats A, B, C, D -> A and B accepted, in_ready=0 from the cycle after B; raise out_ready -> output order A, B, C, D with no loss; in_ready never high while count=2.
4. Full-rate: in_valid=1 and out_ready=1 for 64 consecutive cycles sweeping all 64 6-bit codes in lane 0 -> 64 output beats, each matching the conversion rule; sat_count=1 (lane 1 held at 0).
5. sat_clear: with sat_count=3, assert sat_clear in the same cycle as accepting a beat containing two -32 words -> sat_count=0 on the next cycle.
6. Reset mid-operation: with count=2, pulse rst for 1 cycle -> out_valid=0 and in_ready=0 during rst, in_ready=1 after; the next accepted beat is the first beat output.
